pll_reset_sequencer: RTL and testbench

Supervises the `altera_pll` clock generator (27 MHz `refclk` in, 60 MHz `outclk_0` out). It drives the PLL's `rst`, qualifies `locked` for a stable interval, and only then releases a downstream system reset. It re-sequences the PLL on loss of lock and latches a fault after repeated lock timeouts. It runs entirely on `refclk`, because `outclk_0` is not trustworthy before lock; consumers in the `outclk_0` domain re-synchronize `sys_rst` locally.

---
 rtl/pll_seq_pkg.sv | 14 +
 rtl/sync_2ff.sv | 15 +
 rtl/pll_reset_sequencer.sv | 122 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [7:0] RELOCK_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer for clock-domain crossings.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, qualifies lock and releases the downstream reset; runs on refclk only.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count
);

    localparam int RET_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);

    logic locked_s;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [RET_W-1:0] retries, retries_n;
    logic [7:0]       relock_n;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Lock wins over timeout in WAIT_LOCK; a drop wins over completion in STABLE.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt - CNT_W'(1);
        retries_n = retries;
        relock_n  = relock_count;
        case (state)
            ASSERT_RST: begin
                if (cnt == '0) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = TMO_LD;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = STB_LD;
                end else if (cnt == '0) begin
                    retries_n = retries + RET_W'(1);
                    cnt_n     = PULSE_LD;
                    state_n   = (retries_n == RET_MAX) ? FAULT : ASSERT_RST;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = TMO_LD;
                end else if (cnt == '0) begin
                    state_n   = RUN;
                    cnt_n     = '0;
                    retries_n = '0;
                end
            end
            RUN: begin
                cnt_n = cnt;
                if (!locked_s) begin
                    state_n = ASSERT_RST;
                    cnt_n   = PULSE_LD;
                    if (relock_count != RELOCK_MAX)
                        relock_n = relock_count + 8'd1;
                end
            end
            FAULT: begin
                cnt_n = cnt;
                if (retry_req) begin
                    state_n   = ASSERT_RST;
                    cnt_n     = PULSE_LD;
                    retries_n = '0;
                end
            end
            default: begin
                state_n = ASSERT_RST;
                cnt_n   = PULSE_LD;
            end
        endcase
    end

    // Outputs decode the next state so they switch together with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state        <= ASSERT_RST;
            cnt          <= PULSE_LD;
            retries      <= '0;
            relock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            retries      <= retries_n;
            relock_count <= relock_n;
            pll_rst      <= (state_n == ASSERT_RST) || (state_n == FAULT);
            sys_rst      <= (state_n != RUN);
            ready        <= (state_n == RUN);
            fault        <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: driver steps a phase/elapsed-time reference model, monitor compares outputs.
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;
    localparam int CW = 17;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, retry_req;
    logic       pll_rst, sys_rst, ready, fault;
    logic [7:0] relock_count;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RP),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (LT),
        .MAX_RETRIES         (MR),
        .CNT_W               (CW)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .retry_req    (retry_req),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .relock_count (relock_count)
    );

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       fault;
        logic [7:0] relock;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    bit   done    = 0;

    // Reference model: phase plus cycles elapsed in that phase.
    localparam int P_PULSE = 0, P_WAIT = 1, P_QUAL = 2, P_RUN = 3, P_FAULT = 4;
    int phase   = P_PULSE;
    int elapsed = 0;
    int tries   = 0;
    int losses  = 0;
    bit lk_d1   = 0;
    bit lk_d2   = 0;

    task automatic step(input bit r, input bit pl, input bit rq);
        bit   seen;
        obs_t o;
        seen  = lk_d2;
        lk_d2 = lk_d1;
        lk_d1 = pl;
        if (r) begin
            phase = P_PULSE; elapsed = 0; tries = 0; losses = 0;
        end else begin
            case (phase)
                P_PULSE: begin
                    elapsed++;
                    if (elapsed == RP) begin phase = P_WAIT; elapsed = 0; end
                end
                P_WAIT: begin
                    if (seen) begin
                        phase = P_QUAL; elapsed = 0;
                    end else begin
                        elapsed++;
                        if (elapsed == LT) begin
                            tries++;
                            phase   = (tries == MR) ? P_FAULT : P_PULSE;
                            elapsed = 0;
                        end
                    end
                end
                P_QUAL: begin
                    if (!seen) begin
                        phase = P_WAIT; elapsed = 0;
                    end else begin
                        elapsed++;
                        if (elapsed == LS) begin phase = P_RUN; tries = 0; end
                    end
                end
                P_RUN: begin
                    if (!seen) begin
                        phase = P_PULSE; elapsed = 0;
                        losses = (losses < 255) ? losses + 1 : 255;
                    end
                end
                default: begin
                    if (rq) begin phase = P_PULSE; elapsed = 0; tries = 0; end
                end
            endcase
        end
        o.pll_rst = (phase == P_PULSE) || (phase == P_FAULT);
        o.sys_rst = (phase != P_RUN);
        o.ready   = (phase == P_RUN);
        o.fault   = (phase == P_FAULT);
        o.relock  = 8'(losses);
        exp_q.push_back(o);
    endtask

    task automatic cyc(input bit r, input bit pl, input bit rq);
        rst = r; pll_locked = pl; retry_req = rq;
        step(r, pl, rq);
        @(negedge refclk);
    endtask

    task automatic summary();
        if (!done) begin
            done = 1;
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge refclk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{pll_rst, sys_rst, ready, fault, relock_count};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got pll_rst=%b sys_rst=%b ready=%b fault=%b relock=%0d, want pll_rst=%b sys_rst=%b ready=%b fault=%b relock=%0d",
                             cycle, a.pll_rst, a.sys_rst, a.ready, a.fault, a.relock,
                             e.pll_rst, e.sys_rst, e.ready, e.fault, e.relock);
                    if (n_fail >= 30) summary();
                end
            end
        end
    end

    initial begin : driver
        int len;
        bit val;
        repeat (4) cyc(1, 0, 0);
        // clean bring-up
        repeat (10) cyc(0, 0, 0);
        repeat (30) cyc(0, 1, 0);
        cyc(0, 1, 1);
        // loss of lock in RUN
        cyc(0, 0, 0);
        repeat (30) cyc(0, 1, 0);
        // glitch while qualifying lock
        cyc(0, 0, 0);
        repeat (11) cyc(0, 1, 0);
        cyc(0, 0, 0);
        repeat (30) cyc(0, 1, 0);
        // timeouts into FAULT, then retry
        repeat (100) cyc(0, 0, 0);
        cyc(0, 0, 1);
        repeat (10) cyc(0, 0, 0);
        repeat (30) cyc(0, 1, 0);
        // saturate the relock counter
        for (int i = 0; i < 260; i++) begin
            cyc(0, 0, 0);
            repeat (20) cyc(0, 1, 0);
        end
        // reset while qualifying lock
        repeat (2) cyc(1, 0, 0);
        repeat (10) cyc(0, 1, 0);
        cyc(1, 1, 0);
        repeat (20) cyc(0, 1, 0);
        // random lock behaviour with sporadic retry and reset
        repeat (60) begin
            len = $urandom_range(1, 120);
            val = 1'($urandom_range(0, 1));
            repeat (len) cyc($urandom_range(0, 399) == 0, val, $urandom_range(0, 29) == 0);
        end
        @(posedge refclk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        summary();
    end

endmodule
